// File: rtl/loom_byte_serializer.sv
// Framed serial transmitter: latches a parallel word over valid/ready and shifts it out
// as start bit, data bits, optional even-parity bit and stop bit, with all outputs registered.
module loom_byte_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] n_in,
  input  logic             n_valid,
  output logic             n_ready,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_clk_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_parity;
  logic             r_ser_out;
  logic             r_n_ready;
  logic             r_busy;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_clk_cnt_nxt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic             w_parity_nxt;
  logic             w_cnt_last;
  logic [BW-1:0]    w_sel;
  logic             w_ser_nxt;

  // Handshake: a word transfers on a rising edge where n_valid and n_ready are both high;
  // n_ready is high only in IDLE (including the done cycle), and n_in/n_valid are ignored otherwise.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = '0;
    w_bit_cnt_nxt = r_bit_cnt;
    w_data_nxt    = r_data;
    w_parity_nxt  = r_parity;
    w_cnt_last    = (r_clk_cnt == CNT_MAX);

    unique case (r_state)
      S_IDLE: begin
        if (n_valid && r_n_ready) begin
          w_state_nxt   = S_START;
          w_data_nxt    = n_in;
          w_parity_nxt  = ^n_in;
          w_bit_cnt_nxt = '0;
        end
      end
      S_START: begin
        w_clk_cnt_nxt = w_cnt_last ? '0 : r_clk_cnt + CW'(1);
        if (w_cnt_last) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        w_clk_cnt_nxt = w_cnt_last ? '0 : r_clk_cnt + CW'(1);
        if (w_cnt_last) begin
          if (r_bit_cnt == BIT_MAX) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      S_PARITY: begin
        w_clk_cnt_nxt = w_cnt_last ? '0 : r_clk_cnt + CW'(1);
        if (w_cnt_last) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_clk_cnt_nxt = w_cnt_last ? '0 : r_clk_cnt + CW'(1);
        if (w_cnt_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line is aligned with the state.
    w_sel = MSB_FIRST ? (BIT_MAX - w_bit_cnt_nxt) : w_bit_cnt_nxt;
    unique case (w_state_nxt)
      S_START:  w_ser_nxt = 1'b0;
      S_DATA:   w_ser_nxt = w_data_nxt[w_sel];
      S_PARITY: w_ser_nxt = w_parity_nxt;
      default:  w_ser_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_ser_out <= 1'b1;
      r_n_ready <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_data    <= w_data_nxt;
      r_parity  <= w_parity_nxt;
      r_ser_out <= w_ser_nxt;
      r_n_ready <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (r_state == S_STOP) && w_cnt_last;
    end
  end

  assign n_ready   = r_n_ready;
  assign ser_out   = r_ser_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_loom_byte_serializer.sv
// Bench for loom_byte_serializer: three parameter variants share one stimulus stream and are
// checked every cycle against a frame-position model, plus literal checks of known frames.
module tb_loom_byte_serializer;
  localparam int W   = 8;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [W-1:0] n_in;
  logic       n_valid;
  logic       rdy [3];
  logic       ser [3];
  logic       bsy [3];
  logic       dne [3];
  logic [2:0] dbg [3];
  logic [3:0] obs [3];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  loom_byte_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .n_in(n_in), .n_valid(n_valid), .n_ready(rdy[0]),
    .ser_out(ser[0]), .busy(bsy[0]), .done(dne[0]), .dbg_state(dbg[0]));
  loom_byte_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .n_in(n_in), .n_valid(n_valid), .n_ready(rdy[1]),
    .ser_out(ser[1]), .busy(bsy[1]), .done(dne[1]), .dbg_state(dbg[1]));
  loom_byte_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_nop (
    .clk(clk), .rst(rst), .n_in(n_in), .n_valid(n_valid), .n_ready(rdy[2]),
    .ser_out(ser[2]), .busy(bsy[2]), .done(dne[2]), .dbg_state(dbg[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {rdy[g], bsy[g], dne[g], ser[g]};
  end

  // Model: k = cycles since first START cycle (-1 idle); k == frame length is the done cycle.
  int         k  [3] = '{-1, -1, -1};
  logic [W-1:0] wd [3];
  bit         msb_p [3] = '{1'b1, 1'b0, 1'b1};
  bit         par_p [3] = '{1'b1, 1'b1, 1'b0};

  function automatic int frame_len(int i);
    return (2 + W + int'(par_p[i])) * CPB;
  endfunction

  function automatic logic [3:0] expect_out(int i);
    int slot;
    logic s;
    logic [W-1:0] w;
    w = wd[i];
    if (k[i] < 0) return 4'b1001;
    if (k[i] == frame_len(i)) return 4'b1011;
    slot = k[i] / CPB;
    if (slot == 0) s = 1'b0;
    else if (slot <= W) s = msb_p[i] ? w[3'(W - slot)] : w[3'(slot - 1)];
    else if (par_p[i] && slot == W + 1) s = ^w;
    else s = 1'b1;
    return {3'b010, s};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) k[i] = -1;
      else if (k[i] >= 0 && k[i] < frame_len(i)) k[i] = k[i] + 1;
      else if (n_valid) begin
        k[i]  = 0;
        wd[i] = n_in;
      end else k[i] = -1;
    end
  end

  always @(negedge clk) begin : cmp_p
    logic [3:0] e;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        e = expect_out(i);
        n_cmp++;
        if (obs[i] !== e) begin
          n_fail++;
          $display("FAIL model_inst%0d t=%0t {rdy,busy,done,ser} got=%b expected=%b (k=%0d)",
                   i, $time, obs[i], e, k[i]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  logic [3:0] rec [0:49][0:2];

  // Presents a word for one accepting edge, then records 50 cycles of all three instances.
  task automatic send_frame(input logic [W-1:0] w);
    n_in    = w;
    n_valid = 1'b1;
    @(negedge clk);
    n_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      rec[c][0] = obs[0];
      rec[c][1] = obs[1];
      rec[c][2] = obs[2];
      n_in = W'($urandom);
      if (c != 49) @(negedge clk);
    end
  endtask

  task automatic count_bits(input int inst, input int bitpos, output int cnt);
    cnt = 0;
    for (int c = 0; c < 50; c++) cnt += int'(rec[c][inst][bitpos]);
  endtask

  initial begin
    logic [10:0] exp_main;
    logic [7:0]  exp_lsb;
    logic [7:0]  w2;
    int cnt, gap, guard;

    rst = 1'b1; n_valid = 1'b0; n_in = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ser_%0d", i), 32'(ser[i]), 32'd1);
      check($sformatf("reset_ready_%0d", i), 32'(rdy[i]), 32'd1);
      check($sformatf("reset_busy_%0d", i), 32'(bsy[i]), 32'd0);
      check($sformatf("reset_done_%0d", i), 32'(dne[i]), 32'd0);
      check($sformatf("reset_state_%0d", i), 32'(dbg[i]), 32'd0);
    end
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame 0x2B
    send_frame(8'b0010_1011);
    exp_main = 11'b0_00101011_0_1;
    for (int j = 0; j < 11; j++)
      check($sformatf("basic_slot%0d", j), 32'(rec[j*CPB+1][0][0]), 32'(exp_main[10-j]));
    exp_lsb = 8'b1101_0100;
    for (int j = 0; j < 8; j++)
      check($sformatf("lsb_data%0d", j), 32'(rec[(j+1)*CPB+1][1][0]), 32'(exp_lsb[7-j]));
    count_bits(0, 2, cnt); check("basic_busy_cycles", 32'(cnt), 32'd44);
    count_bits(0, 1, cnt); check("basic_done_pulses", 32'(cnt), 32'd1);
    check("basic_done_cycle", 32'(rec[44][0]), 32'b1011);
    count_bits(2, 2, cnt); check("nopar_busy_cycles", 32'(cnt), 32'd40);

    // Odd-parity word
    send_frame(8'h07);
    check("parity_07", 32'(rec[9*CPB+1][0][0]), 32'd1);
    check("nopar_stop_07", 32'(rec[9*CPB+1][2][0]), 32'd1);
    check("nopar_done_07", 32'(rec[40][2]), 32'b1011);

    // Back-to-back with n_valid held
    n_in = 8'hA5; n_valid = 1'b1;
    @(negedge clk);
    n_in = 8'h3C;
    guard = 0;
    while (bsy[0] !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
    check("b2b_frame1_end_timeout", 32'(guard < 100), 32'd1);
    gap = 0;
    while (bsy[0] !== 1'b1 && gap < 100) begin @(negedge clk); gap++; end
    check("b2b_idle_gap", 32'(gap), 32'd1);
    w2 = 8'h3C;
    for (int c = 0; c < 44; c++) begin
      if (c == 2) n_valid = 1'b0;
      n_in = W'($urandom);
      if (c % CPB == 1) begin
        if (c / CPB == 0) check("b2b_start", 32'(ser[0]), 32'd0);
        else if (c / CPB <= 8) check($sformatf("b2b_data%0d", c / CPB - 1), 32'(ser[0]), 32'(w2[8 - c / CPB]));
        else if (c / CPB == 9) check("b2b_parity", 32'(ser[0]), 32'(^w2));
      end
      @(negedge clk);
    end
    repeat (10) @(negedge clk);

    // Reset during DATA bit 3
    n_in = 8'hE6; n_valid = 1'b1;
    @(negedge clk);
    n_valid = 1'b0;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ser", 32'(ser[0]), 32'd1);
    check("abort_ready", 32'(rdy[0]), 32'd1);
    check("abort_busy", 32'(bsy[0]), 32'd0);
    check("abort_done", 32'(dne[0]), 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin cnt += int'(dne[0]); @(negedge clk); end
    check("abort_no_done", 32'(cnt), 32'd0);
    send_frame(8'hC9);
    count_bits(0, 2, cnt); check("post_abort_busy", 32'(cnt), 32'd44);
    count_bits(0, 1, cnt); check("post_abort_done", 32'(cnt), 32'd1);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      n_valid = 1'b1;
      for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
        n_in = W'($urandom);
        @(negedge clk);
      end
      n_valid = 1'b0;
      for (int c = 0; c < int'($urandom_range(20, 60)); c++) begin
        n_in    = W'($urandom);
        n_valid = ($urandom_range(0, 7) == 0);
        rst     = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      rst = 1'b0;
      n_valid = 1'b0;
    end
    repeat (60) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
